// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared defaults and width helper for the mixer integrator
package mixer_pkg;

    localparam int DEF_WINDOW_LEN  = 1024;
    localparam int DEF_SYNC_STAGES = 2;

    // Ceiling log2; used to size counters that must hold values up to v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pulse_sync.sv
// rtl/pulse_sync.sv - multi-flop synchronizer for a single asynchronous pulse line
module pulse_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/mixer_integrator.sv
// rtl/mixer_integrator.sv - windowed high-cycle integrator for the XOR mixer output
module mixer_integrator
    import mixer_pkg::*;
#(
    parameter  int WINDOW_LEN  = DEF_WINDOW_LEN,
    parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int CNT_W       = clog2(WINDOW_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mixer_in,
    input  logic             enable,
    input  logic             clear,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun
);

    logic             s_in;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] final_sum;
    logic             win_end;
    logic             accept;
    logic             load_result;
    logic             drop_result;

    pulse_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mixer_in),
        .q     (s_in)
    );

    assign win_end   = enable && (sample_cnt == CNT_W'(WINDOW_LEN - 1));
    assign final_sum = acc + CNT_W'(s_in);
    assign accept    = result_valid && result_ready;

    // The slot can take a new window if it is empty or being drained this same edge.
    always_comb begin
        load_result = 1'b0;
        drop_result = 1'b0;
        if (win_end) begin
            if (!result_valid || result_ready) begin
                load_result = 1'b1;
            end else begin
                drop_result = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            sample_cnt <= '0;
        end else if (clear) begin
            acc        <= '0;
            sample_cnt <= '0;
        end else if (win_end) begin
            acc        <= '0;
            sample_cnt <= '0;
        end else if (enable) begin
            acc        <= final_sum;
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    // result value is deliberately left untouched by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (clear) begin
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load_result) begin
                result       <= final_sum;
                result_valid <= 1'b1;
            end else if (accept) begin
                result_valid <= 1'b0;
            end
            if (drop_result) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mixer_integrator.sv
// tb/tb_mixer_integrator.sv - scoreboard bench for mixer_integrator (WINDOW_LEN=16, SYNC_STAGES=2)
module tb_mixer_integrator;

    logic       clk;
    logic       rst_n;
    logic       mixer_in;
    logic       enable;
    logic       clear;
    logic [4:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       overrun;

    int checks;
    int errors;
    int exp_q[$];

    mixer_integrator #(
        .WINDOW_LEN  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mixer_in     (mixer_in),
        .enable       (enable),
        .clear        (clear),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && result_valid && result_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result actual=%0d required=none", result);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(result) !== e) begin
                    errors++;
                    $display("FAIL result_value actual=%0d required=%0d", result, e);
                end
            end
        end
    end

    initial begin
        bit [3:0] pat;
        checks       = 0;
        errors       = 0;
        pat          = 4'b0011;
        rst_n        = 1'b0;
        mixer_in     = 1'b0;
        enable       = 1'b0;
        clear        = 1'b0;
        result_ready = 1'b1;
        tick(2);
        check("reset_result", int'(result), 0);
        check("reset_valid", int'(result_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        rst_n = 1'b1;

        // 1: zero input, two back-to-back windows
        tick(3);
        exp_q.push_back(0);
        exp_q.push_back(0);
        enable = 1'b1;
        tick(32);
        enable = 1'b0;
        tick(2);
        check("p1_drained", exp_q.size(), 0);
        check("p1_overrun", int'(overrun), 0);
        check("p1_valid_low", int'(result_valid), 0);

        // 2: full scale, then 50% duty pattern
        mixer_in = 1'b1;
        tick(3);
        exp_q.push_back(16);
        enable = 1'b1;
        tick(16);
        enable = 1'b0;
        exp_q.push_back(8);
        for (int i = 0; i < 20; i++) begin
            mixer_in = pat[i % 4];
            enable   = (i >= 4);
            tick();
        end
        enable = 1'b0;
        tick(3);
        check("p2_drained", exp_q.size(), 0);

        // 3: consumer stalls across two windows
        result_ready = 1'b0;
        mixer_in     = 1'b1;
        tick(3);
        enable = 1'b1;
        tick(16);
        enable = 1'b0;
        check("p3_valid_first", int'(result_valid), 1);
        check("p3_result_first", int'(result), 16);
        check("p3_overrun_first", int'(overrun), 0);
        mixer_in = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(16);
        enable = 1'b0;
        check("p3_overrun_set", int'(overrun), 1);
        check("p3_valid_held", int'(result_valid), 1);
        check("p3_result_held", int'(result), 16);
        exp_q.push_back(16);
        result_ready = 1'b1;
        tick();
        check("p3_valid_after_accept", int'(result_valid), 0);
        check("p3_overrun_sticky", int'(overrun), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("p3_overrun_cleared", int'(overrun), 0);
        check("p3_result_kept", int'(result), 16);
        check("p3_drained", exp_q.size(), 0);

        // 4: pause mid-window
        mixer_in = 1'b1;
        tick(3);
        exp_q.push_back(16);
        enable = 1'b1;
        tick(8);
        enable = 1'b0;
        tick(5);
        check("p4_no_early_valid", int'(result_valid), 0);
        enable = 1'b1;
        tick(7);
        check("p4_not_yet", int'(result_valid), 0);
        tick();
        check("p4_valid", int'(result_valid), 1);
        enable = 1'b0;
        tick(2);
        check("p4_drained", exp_q.size(), 0);

        // 5: clear on the window-end cycle
        enable = 1'b1;
        tick(15);
        clear = 1'b1;
        tick();
        clear  = 1'b0;
        enable = 1'b0;
        tick();
        check("p5_no_valid", int'(result_valid), 0);
        exp_q.push_back(16);
        enable = 1'b1;
        tick(15);
        check("p5_full_window_wait", int'(result_valid), 0);
        tick();
        check("p5_valid", int'(result_valid), 1);
        enable = 1'b0;
        tick(2);
        check("p5_drained", exp_q.size(), 0);

        // 6: asynchronous reset mid-window
        enable = 1'b1;
        tick(7);
        #2;
        rst_n = 1'b0;
        #1;
        check("p6_rst_result", int'(result), 0);
        check("p6_rst_valid", int'(result_valid), 0);
        check("p6_rst_overrun", int'(overrun), 0);
        enable = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        exp_q.push_back(16);
        enable = 1'b1;
        tick(15);
        check("p6_not_yet", int'(result_valid), 0);
        tick();
        check("p6_valid", int'(result_valid), 1);
        check("p6_result", int'(result), 16);
        enable = 1'b0;
        tick(3);
        check("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
